// File: rtl/brc_pkg.sv
// brc_pkg: shared types and constants for the serial branch comparator
package brc_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, CMP, DONE} brc_state_e;
endpackage

// File: rtl/nibble_cmp.sv
// nibble_cmp: 4-bit unsigned magnitude compare slice
module nibble_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/brc_serial.sv
// brc_serial: MSB-first nibble-serial branch comparator with valid/ready on both sides
module brc_serial
  import brc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal
);
  localparam int NN = WIDTH / NIBBLE_W;
  localparam int CW = NN > 1 ? $clog2(NN) : 1;
  brc_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, msb_flip;
  logic gt, eq, lt, last;
  nibble_cmp u_cmp (
    .a (a_q[WIDTH-1 -: NIBBLE_W]),
    .b (b_q[WIDTH-1 -: NIBBLE_W]),
    .gt(gt),
    .eq(eq),
    .lt(lt)
  );
  assign last = cnt == CW'(NN - 1);
  // flipping the sign bit of both operands turns a signed compare into an unsigned one
  assign msb_flip = {~i_br_un, {(WIDTH-1){1'b0}}};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (i_valid ? CMP : IDLE) :
               state == CMP  ? (!eq || last ? DONE : CMP) :
                               (i_ready ? IDLE : DONE);
  end
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      o_br_less  <= 1'b0;
      o_br_equal <= 1'b0;
    end else if (state == IDLE && i_valid) begin
      a_q <= i_rs1_data ^ msb_flip;
      b_q <= i_rs2_data ^ msb_flip;
      cnt <= '0;
    end else if (state == CMP) begin
      if (!eq || last) begin
        o_br_less  <= lt & ~gt;
        o_br_equal <= eq;
      end else begin
        a_q <= a_q << NIBBLE_W;
        b_q <= b_q << NIBBLE_W;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_brc_serial.sv
// tb_brc_serial: directed and randomized checks of brc_serial against an arithmetic reference
module tb_brc_serial;
  localparam int W  = 32;
  localparam int NN = W / 4;
  logic i_clk = 0, i_rst_n = 0, i_valid = 0, i_br_un = 0, i_ready = 0;
  logic [W-1:0] i_rs1_data = '0, i_rs2_data = '0;
  logic o_ready, o_valid, o_br_less, o_br_equal;
  int checks = 0, errors = 0;
  brc_serial #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_br_un(i_br_un),
    .o_valid(o_valid), .i_ready(i_ready), .o_br_less(o_br_less), .o_br_equal(o_br_equal)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int exp_k(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < NN; i++)
      if (((a >> (4 * (NN - 1 - i))) & 32'hF) != ((b >> (4 * (NN - 1 - i))) & 32'hF)) return i + 1;
    return NN;
  endfunction
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic un,
                     input int bp, input bit poke);
    int n;
    logic el, ee, ol, oe;
    el = un ? (a < b) : ($signed(a) < $signed(b));
    ee = a == b;
    @(negedge i_clk);
    chk("ready_before", o_ready, 1);
    i_valid = 1; i_rs1_data = a; i_rs2_data = b; i_br_un = un; i_ready = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 0; i_rs1_data = $urandom; i_rs2_data = $urandom; i_br_un = $urandom;
    chk("ready_busy", o_ready, 0);
    n = 0;
    while (o_valid !== 1'b1 && n < 40) begin
      i_valid = poke && n == 0;
      i_rs1_data = $urandom; i_rs2_data = $urandom;
      @(negedge i_clk);
      n++;
    end
    i_valid = 0;
    chk("latency", n, exp_k(a, b));
    chk("less", o_br_less, el);
    chk("equal", o_br_equal, ee);
    ol = o_br_less; oe = o_br_equal;
    for (int i = 0; i < bp; i++) begin
      i_valid = poke;
      @(negedge i_clk);
      chk("bp_valid", o_valid, 1);
      chk("bp_ready", o_ready, 0);
      chk("bp_flags", {o_br_less, o_br_equal}, {ol, oe});
    end
    i_valid = 0;
    i_ready = 1;
    @(negedge i_clk);
    i_ready = 0;
    chk("post_ready", o_ready, 1);
    chk("post_valid", o_valid, 0);
    chk("post_flags", {o_br_less, o_br_equal}, {el, ee});
  endtask
  initial begin
    logic [W-1:0] a, b;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_flags", {o_br_less, o_br_equal}, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    run(32'h8000_0000, 32'h0000_0001, 1, 0, 0);
    run(32'h8000_0000, 32'h0000_0001, 0, 0, 0);
    run(32'h1234_5678, 32'h1234_5678, 0, 0, 0);
    run(32'hFFFF_FFF5, 32'hFFFF_FFF6, 1, 3, 0);
    run(32'h0F00_0000, 32'h0E00_0000, 1, 1, 1);
    run(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1);
    run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 2, 0);
    @(negedge i_clk);
    i_valid = 1; i_rs1_data = 32'hCAFE_BABE; i_rs2_data = 32'hCAFE_BABE; i_br_un = 1;
    @(negedge i_clk);
    i_valid = 0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_flags", {o_br_less, o_br_equal}, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    chk("midrst_hold", {o_ready, o_valid}, 2'b10);
    run(32'd3, 32'd3, 1, 0, 0);
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        default: b = a ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NN - 1)));
      endcase
      run(a, b, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
